alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 199 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU with tagged results and an in-order result FIFO.
// Operands are registered on accept, the result rides a LATENCY-stage valid/tag/data
// pipeline and lands in a DEPTH-entry FIFO whose head is mirrored into output registers.
// A single occupancy counter (pipeline + FIFO) gates acceptance, so the FIFO never overflows.
module alu_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ROB_IX  = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              flush_in,
  input  logic              valid_in,
  input  logic [WIDTH-1:0]  rval1_in,
  input  logic [WIDTH-1:0]  rval2_in,
  input  logic [3:0]        aluFunc_in,
  input  logic [ROB_IX:0]   rob_ix_in,
  input  logic              read_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic [WIDTH-1:0]  data_out,
  output logic [ROB_IX:0]   rob_ix_out
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);

  localparam logic [3:0] FnAdd  = 4'd0;
  localparam logic [3:0] FnSub  = 4'd1;
  localparam logic [3:0] FnAnd  = 4'd2;
  localparam logic [3:0] FnOr   = 4'd3;
  localparam logic [3:0] FnXor  = 4'd4;
  localparam logic [3:0] FnSlt  = 4'd5;
  localparam logic [3:0] FnSltu = 4'd6;
  localparam logic [3:0] FnSll  = 4'd7;
  localparam logic [3:0] FnSrl  = 4'd8;
  localparam logic [3:0] FnSra  = 4'd9;

  // Stage 0 holds the raw operands; the ALU result is formed between stage 0 and stage 1.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_func;
  logic [LATENCY-1:0] r_v;
  logic [ROB_IX:0]  r_t [LATENCY];

  logic [SW-1:0]    w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_exit_data;
  logic [ROB_IX:0]  w_exit_tag;

  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [ROB_IX:0]  r_mem_tag  [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    w_wptr_inc;
  logic [PW-1:0]    w_rptr_inc;
  logic [CW-1:0]    r_fcnt;
  logic [CW-1:0]    w_fcnt_nxt;
  logic [CW-1:0]    r_cnt;

  logic             r_valid_out;
  logic [WIDTH-1:0] r_data_out;
  logic [ROB_IX:0]  r_rob_out;
  logic [WIDTH-1:0] w_head_data_nxt;
  logic [ROB_IX:0]  w_head_tag_nxt;

  logic w_accept;
  logic w_push;
  logic w_pop;

  assign ready_out  = (r_cnt < DepthC);
  assign valid_out  = r_valid_out;
  assign data_out   = r_data_out;
  assign rob_ix_out = r_rob_out;

  assign w_accept   = valid_in && ready_out;
  assign w_push     = r_v[LATENCY-1];
  assign w_pop      = read_in && r_valid_out;
  assign w_exit_tag = r_t[LATENCY-1];

  assign w_shamt    = r_b[SW-1:0];
  assign w_wptr_inc = (r_wptr == PtrLast) ? '0 : r_wptr + 1'b1;
  assign w_rptr_inc = (r_rptr == PtrLast) ? '0 : r_rptr + 1'b1;
  assign w_fcnt_nxt = r_fcnt + CW'(w_push) - CW'(w_pop);

  // ALU on the stage-0 operands; undefined function codes yield zero.
  always_comb begin
    w_alu = '0;
    case (r_func)
      FnAdd:   w_alu = r_a + r_b;
      FnSub:   w_alu = r_a - r_b;
      FnAnd:   w_alu = r_a & r_b;
      FnOr:    w_alu = r_a | r_b;
      FnXor:   w_alu = r_a ^ r_b;
      FnSlt:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      FnSltu:  w_alu = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
      FnSll:   w_alu = r_a << w_shamt;
      FnSrl:   w_alu = r_a >> w_shamt;
      FnSra:   w_alu = $unsigned($signed(r_a) >>> w_shamt);
      default: w_alu = '0;
    endcase
  end

  // Result data stages 1..LATENCY-1; with LATENCY=1 the ALU output exits directly.
  if (LATENCY > 1) begin : g_deep
    logic [WIDTH-1:0] r_d [1:LATENCY-1];

    // Shift the computed result down the data pipeline every cycle.
    always_ff @(posedge clk_in) begin
      r_d[1] <= w_alu;
      for (int i = 2; i < LATENCY; i++) begin
        r_d[i] <= r_d[i-1];
      end
    end

    assign w_exit_data = r_d[LATENCY-1];
  end else begin : g_shallow
    assign w_exit_data = w_alu;
  end

  // Capture operands on accept and shift tags alongside the valid bits.
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_a    <= rval1_in;
      r_b    <= rval2_in;
      r_func <= aluFunc_in;
      r_t[0] <= rob_ix_in;
    end
    for (int i = 1; i < LATENCY; i++) begin
      r_t[i] <= r_t[i-1];
    end
  end

  // FIFO storage write; stale writes during flush/reset are harmless as pointers reset.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= w_exit_data;
      r_mem_tag[r_wptr]  <= w_exit_tag;
    end
  end

  // Next head: on pop take the entry behind the head, or the exiting result when it
  // lands into an otherwise-emptied FIFO; an exit into an empty FIFO becomes the head.
  always_comb begin
    w_head_data_nxt = r_data_out;
    w_head_tag_nxt  = r_rob_out;
    if (w_pop) begin
      if (r_fcnt > CW'(1)) begin
        w_head_data_nxt = r_mem_data[w_rptr_inc];
        w_head_tag_nxt  = r_mem_tag[w_rptr_inc];
      end else if (w_push) begin
        w_head_data_nxt = w_exit_data;
        w_head_tag_nxt  = w_exit_tag;
      end
    end else if ((r_fcnt == '0) && w_push) begin
      w_head_data_nxt = w_exit_data;
      w_head_tag_nxt  = w_exit_tag;
    end
  end

  // Control state: pipeline valids, FIFO pointers, occupancy and the registered head.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_v         <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fcnt      <= '0;
      r_cnt       <= '0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_rob_out   <= '0;
    end else if (flush_in) begin
      r_v         <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fcnt      <= '0;
      r_cnt       <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_v[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) begin
        r_v[i] <= r_v[i-1];
      end
      if (w_push) r_wptr <= w_wptr_inc;
      if (w_pop)  r_rptr <= w_rptr_inc;
      r_fcnt      <= w_fcnt_nxt;
      r_cnt       <= r_cnt + CW'(w_accept) - CW'(w_pop);
      r_valid_out <= (w_fcnt_nxt != '0);
      r_data_out  <= w_head_data_nxt;
      r_rob_out   <= w_head_tag_nxt;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe at default parameters.
module tb_alu_pipe;

  logic        clk_in;
  logic        rst_n_in;
  logic        flush_in;
  logic        valid_in;
  logic [31:0] rval1_in;
  logic [31:0] rval2_in;
  logic [3:0]  aluFunc_in;
  logic [2:0]  rob_ix_in;
  logic        read_in;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] data_out;
  logic [2:0]  rob_ix_out;

  int n_total = 0;
  int n_bad   = 0;

  alu_pipe dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .flush_in   (flush_in),
    .valid_in   (valid_in),
    .rval1_in   (rval1_in),
    .rval2_in   (rval2_in),
    .aluFunc_in (aluFunc_in),
    .rob_ix_in  (rob_ix_in),
    .read_in    (read_in),
    .ready_out  (ready_out),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .rob_ix_out (rob_ix_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] tag);
    valid_in   = 1'b1;
    aluFunc_in = f;
    rval1_in   = a;
    rval2_in   = b;
    rob_ix_in  = tag;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (valid_out) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    tick();
    tick();
    n_total++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%0b want=1", ready_out); end
    n_total++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b want=0", valid_out); end
    n_total++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%h want=0", data_out); end
    n_total++; if (rob_ix_out !== 3'd0) begin n_bad++; $display("FAIL reset_tag got=%0d want=0", rob_ix_out); end
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_add();
    read_in = 1'b1;
    drive(4'd0, 32'd5, 32'hFFFF_FFF9, 3'd3);
    tick();
    valid_in = 1'b0;
    tick();
    n_total++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL add_early1 got=%0b want=0", valid_out); end
    tick();
    n_total++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL add_early2 got=%0b want=0", valid_out); end
    tick();
    n_total++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL add_valid got=%0b want=1", valid_out); end
    n_total++; if (data_out !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL add_data got=%h want=fffffffe", data_out); end
    n_total++; if (rob_ix_out !== 3'd3) begin n_bad++; $display("FAIL add_tag got=%0d want=3", rob_ix_out); end
    tick();
    n_total++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL add_popped got=%0b want=0", valid_out); end
    read_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  f [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] e [4];
    f[0] = 4'd9; a[0] = 32'h8000_0000; b[0] = 32'd4;          e[0] = 32'hF800_0000;
    f[1] = 4'd8; a[1] = 32'h8000_0000; b[1] = 32'd4;          e[1] = 32'h0800_0000;
    f[2] = 4'd6; a[2] = 32'd1;         b[2] = 32'hFFFF_FFFF;  e[2] = 32'd1;
    f[3] = 4'd5; a[3] = 32'd1;         b[3] = 32'hFFFF_FFFF;  e[3] = 32'd0;
    read_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(f[i], a[i], b[i], 3'(i));
      tick();
    end
    valid_in = 1'b0;
    n_total++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL b2b_full got=%0b want=0", ready_out); end
    for (int i = 0; i < 4; i++) begin
      n_total++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL b2b_valid%0d got=%0b want=1", i, valid_out); end
      n_total++; if (data_out !== e[i]) begin n_bad++; $display("FAIL b2b_data%0d got=%h want=%h", i, data_out, e[i]); end
      n_total++; if (rob_ix_out !== 3'(i)) begin n_bad++; $display("FAIL b2b_tag%0d got=%0d want=%0d", i, rob_ix_out, i); end
      read_in = 1'b1;
      tick();
      read_in = 1'b0;
    end
    n_total++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got=%0b want=0", valid_out); end
    n_total++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got=%0b want=1", ready_out); end
  endtask

  task automatic test_full();
    logic [31:0] e [4];
    logic [2:0]  t [4];
    bit ok;
    e[0] = 32'd11; t[0] = 3'd1;
    e[1] = 32'd12; t[1] = 3'd2;
    e[2] = 32'd13; t[2] = 3'd3;
    e[3] = 32'd30; t[3] = 3'd5;
    read_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'd0, 32'(i), 32'd10, 3'(i));
      tick();
      n_total++;
      if (ready_out !== ((i < 3) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL full_ready%0d got=%0b want=%0b", i, ready_out, (i < 3));
      end
    end
    valid_in = 1'b0;
    tick();
    tick();
    n_total++; if (data_out !== 32'd10) begin n_bad++; $display("FAIL full_head got=%h want=a", data_out); end
    read_in = 1'b1;
    tick();
    read_in = 1'b0;
    n_total++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL full_reopen got=%0b want=1", ready_out); end
    drive(4'd0, 32'd20, 32'd10, 3'd5);
    tick();
    valid_in = 1'b0;
    n_total++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL full_refill got=%0b want=0", ready_out); end
    for (int i = 0; i < 4; i++) begin
      wait_valid(ok);
      n_total++; if (!ok) begin n_bad++; $display("FAIL full_timeout%0d got=no_result want=result", i); end
      n_total++; if (data_out !== e[i]) begin n_bad++; $display("FAIL full_data%0d got=%h want=%h", i, data_out, e[i]); end
      n_total++; if (rob_ix_out !== t[i]) begin n_bad++; $display("FAIL full_tag%0d got=%0d want=%0d", i, rob_ix_out, t[i]); end
      read_in = 1'b1;
      tick();
      read_in = 1'b0;
    end
    n_total++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL full_drained got=%0b want=0", valid_out); end
  endtask

  task automatic test_ops();
    logic [3:0]  f [8];
    logic [31:0] a [8];
    logic [31:0] b [8];
    logic [31:0] e [8];
    int op_ix = 0;
    int res_ix = 0;
    bit acc;
    f[0] = 4'd1;  a[0] = 32'd3;          b[0] = 32'd5;          e[0] = 32'hFFFF_FFFE;
    f[1] = 4'd2;  a[1] = 32'hF0F0_F0F0;  b[1] = 32'hFF00_FF00;  e[1] = 32'hF000_F000;
    f[2] = 4'd3;  a[2] = 32'hF0F0_F0F0;  b[2] = 32'hFF00_FF00;  e[2] = 32'hFFF0_FFF0;
    f[3] = 4'd4;  a[3] = 32'hF0F0_F0F0;  b[3] = 32'hFF00_FF00;  e[3] = 32'h0FF0_0FF0;
    f[4] = 4'd7;  a[4] = 32'd1;          b[4] = 32'd33;         e[4] = 32'd2;
    f[5] = 4'd12; a[5] = 32'hFFFF_FFFF;  b[5] = 32'd1;          e[5] = 32'd0;
    f[6] = 4'd8;  a[6] = 32'h8000_0000;  b[6] = 32'd32;         e[6] = 32'h8000_0000;
    f[7] = 4'd9;  a[7] = 32'h7FFF_FFF0;  b[7] = 32'd4;          e[7] = 32'h07FF_FFFF;
    read_in = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (op_ix < 8) drive(f[op_ix], a[op_ix], b[op_ix], 3'(op_ix));
      else valid_in = 1'b0;
      acc = valid_in && ready_out;
      tick();
      if (acc) op_ix++;
      if (valid_out && res_ix < 8) begin
        n_total++; if (data_out !== e[res_ix]) begin n_bad++; $display("FAIL ops_data%0d got=%h want=%h", res_ix, data_out, e[res_ix]); end
        n_total++; if (rob_ix_out !== 3'(res_ix)) begin n_bad++; $display("FAIL ops_tag%0d got=%0d want=%0d", res_ix, rob_ix_out, res_ix); end
        res_ix++;
      end
    end
    valid_in = 1'b0;
    read_in  = 1'b0;
    n_total++; if (res_ix != 8) begin n_bad++; $display("FAIL ops_count got=%0d want=8", res_ix); end
  endtask

  task automatic test_hold();
    read_in = 1'b0;
    drive(4'd4, 32'h1234_5678, 32'hFFFF_FFFF, 3'd6);
    tick();
    valid_in = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 3'd1);
    valid_in = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      n_total++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL hold_valid%0d got=%0b want=1", i, valid_out); end
      n_total++; if (data_out !== 32'hEDCB_A987) begin n_bad++; $display("FAIL hold_data%0d got=%h want=edcba987", i, data_out); end
      n_total++; if (rob_ix_out !== 3'd6) begin n_bad++; $display("FAIL hold_tag%0d got=%0d want=6", i, rob_ix_out); end
      tick();
    end
    read_in = 1'b1;
    tick();
    read_in = 1'b0;
    n_total++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL hold_pop got=%0b want=0", valid_out); end
  endtask

  task automatic test_flush();
    int seen = 0;
    bit ok;
    read_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'd0, 32'(i), 32'd1, 3'(i));
      tick();
    end
    drive(4'd0, 32'd50, 32'd0, 3'd7);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    valid_in = 1'b0;
    n_total++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL flush_ready got=%0b want=1", ready_out); end
    n_total++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%0b want=0", valid_out); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid_out) seen++;
    end
    n_total++; if (seen != 0) begin n_bad++; $display("FAIL flush_leak got=%0d want=0", seen); end
    for (int i = 0; i < 3; i++) begin
      drive(4'd0, 32'(100 + i), 32'd0, 3'(4 + i));
      tick();
    end
    valid_in = 1'b0;
    n_total++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL flush_cnt got=%0b want=1", ready_out); end
    for (int i = 0; i < 3; i++) begin
      wait_valid(ok);
      n_total++; if (!ok) begin n_bad++; $display("FAIL flush_timeout%0d got=no_result want=result", i); end
      n_total++; if (data_out !== 32'(100 + i)) begin n_bad++; $display("FAIL flush_data%0d got=%h want=%h", i, data_out, 100 + i); end
      read_in = 1'b1;
      tick();
      read_in = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    read_in = 1'b0;
    drive(4'd0, 32'd7, 32'd0, 3'd1);
    tick();
    drive(4'd0, 32'd8, 32'd0, 3'd2);
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    tick();
    n_total++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL rmid_pre got=%0b want=1", valid_out); end
    rst_n_in = 1'b0;
    flush_in = 1'b1;
    tick();
    rst_n_in = 1'b1;
    flush_in = 1'b0;
    n_total++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got=%0b want=0", valid_out); end
    n_total++; if (data_out !== 32'd0) begin n_bad++; $display("FAIL rmid_data got=%h want=0", data_out); end
    n_total++; if (rob_ix_out !== 3'd0) begin n_bad++; $display("FAIL rmid_tag got=%0d want=0", rob_ix_out); end
    n_total++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL rmid_ready got=%0b want=1", ready_out); end
    drive(4'd1, 32'd9, 32'd2, 3'd5);
    tick();
    valid_in = 1'b0;
    tick();
    n_total++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rmid_early1 got=%0b want=0", valid_out); end
    tick();
    n_total++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rmid_early2 got=%0b want=0", valid_out); end
    tick();
    n_total++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL rmid_new_valid got=%0b want=1", valid_out); end
    n_total++; if (data_out !== 32'd7) begin n_bad++; $display("FAIL rmid_new_data got=%h want=7", data_out); end
    n_total++; if (rob_ix_out !== 3'd5) begin n_bad++; $display("FAIL rmid_new_tag got=%0d want=5", rob_ix_out); end
    read_in = 1'b1;
    tick();
    read_in = 1'b0;
    n_total++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rmid_no_stale got=%0b want=0", valid_out); end
  endtask

  initial begin
    rst_n_in   = 1'b0;
    flush_in   = 1'b0;
    valid_in   = 1'b0;
    rval1_in   = '0;
    rval2_in   = '0;
    aluFunc_in = '0;
    rob_ix_in  = '0;
    read_in    = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_full();
    test_ops();
    test_hold();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
